// File: rtl/alu593_cmd_sequencer.sv
// ALU593 command sequencer: runs a stored program of {op, A, B} commands through the
// ALU start/done handshake and keeps each 16-bit result at the matching index.
module alu593_cmd_sequencer #(
  parameter int         DEPTH     = 32,
  parameter logic [3:0] NOOP_CODE = 4'h0,
  parameter int         TIMEOUT   = 64,
  localparam int        AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_wr_en,
  input  logic [AW-1:0] cmd_wr_addr,
  input  logic [19:0]   cmd_wr_data,
  input  logic          run,
  input  logic [AW:0]   cmd_count,
  output logic [7:0]    alu_A,
  output logic [7:0]    alu_B,
  output logic [3:0]    alu_op,
  output logic          alu_start,
  input  logic          alu_done,
  input  logic [15:0]   alu_result,
  input  logic [AW-1:0] res_rd_addr,
  output logic [15:0]   res_rd_data,
  output logic          busy,
  output logic          seq_done,
  output logic          err
);

  localparam int          WW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_STORE  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t          state_r, state_next;
  logic [AW-1:0]   ptr_r, ptr_next;
  logic [AW:0]     count_r, count_next;
  logic [WW-1:0]   wait_r, wait_next;
  logic [15:0]     result_r, result_next;
  logic            start_next, busy_next, done_next, err_next;
  logic            fetch_s, store_s;

  logic [19:0]     cmd_mem [DEPTH];
  logic [15:0]     res_mem [DEPTH];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state and next-value logic for every registered control output
  always_comb begin
    state_next  = state_r;
    ptr_next    = ptr_r;
    count_next  = count_r;
    wait_next   = wait_r;
    result_next = result_r;
    start_next  = alu_start;
    busy_next   = busy;
    done_next   = 1'b0;
    err_next    = err;
    fetch_s     = 1'b0;
    store_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          if (cmd_count == '0) begin
            done_next = 1'b1;
          end else begin
            count_next = (cmd_count > DEPTH_C) ? DEPTH_C : cmd_count;
            err_next   = 1'b0;
            ptr_next   = '0;
            busy_next  = 1'b1;
            state_next = S_FETCH;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        fetch_s    = 1'b1;
        start_next = 1'b1;
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        wait_next = '0;
        // A no-op never gets a done back, so it is retired here with a zero result
        if (alu_op == NOOP_CODE) begin
          result_next = 16'h0000;
          start_next  = 1'b0;
          state_next  = S_STORE;
        end else begin
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          result_next = alu_result;
          start_next  = 1'b0;
          state_next  = S_STORE;
        end else if (wait_r == TO_LAST) begin
          start_next  = 1'b0;
          err_next    = 1'b1;
          busy_next   = 1'b0;
          state_next  = S_IDLE;
        end else begin
          wait_next   = wait_r + WW'(1);
        end
      end
      S_STORE: begin
        store_s = 1'b1;
        if ({1'b0, ptr_r} == count_r - (AW+1)'(1)) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = S_FINISH;
        end else begin
          ptr_next   = ptr_r + AW'(1);
          state_next = S_FETCH;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        start_next = 1'b0;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r       <= '0;
      count_r     <= '0;
      wait_r      <= '0;
      result_r    <= 16'h0000;
      alu_A       <= 8'h00;
      alu_B       <= 8'h00;
      alu_op      <= 4'h0;
      alu_start   <= 1'b0;
      busy        <= 1'b0;
      seq_done    <= 1'b0;
      err         <= 1'b0;
      res_rd_data <= 16'h0000;
    end else begin
      ptr_r       <= ptr_next;
      count_r     <= count_next;
      wait_r      <= wait_next;
      result_r    <= result_next;
      alu_start   <= start_next;
      busy        <= busy_next;
      seq_done    <= done_next;
      err         <= err_next;
      res_rd_data <= res_mem[res_rd_addr];
      if (fetch_s) begin
        {alu_op, alu_A, alu_B} <= cmd_mem[ptr_r];
      end
    end
  end

  // Storage arrays are deliberately left out of reset so contents survive it
  always_ff @(posedge clk) begin
    if (cmd_wr_en && !busy) begin
      cmd_mem[cmd_wr_addr] <= cmd_wr_data;
    end
    if (store_s) begin
      res_mem[ptr_r] <= result_r;
    end
  end

endmodule

// File: tb/tb_alu593_cmd_sequencer.sv
// Directed bench for alu593_cmd_sequencer with a behavioural ALU and a per-cycle
// checker that compares issued commands and sequence completion against the loaded program.
module tb_alu593_cmd_sequencer;

  localparam logic [3:0] NOOP = 4'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_wr_en = 1'b0;
  logic [4:0]  cmd_wr_addr = 5'd0;
  logic [19:0] cmd_wr_data = 20'd0;
  logic        run = 1'b0;
  logic [5:0]  cmd_count = 6'd0;
  logic [7:0]  alu_A, alu_B;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'd0;
  logic [4:0]  res_rd_addr = 5'd0;
  logic [15:0] res_rd_data;
  logic        busy, seq_done, err;

  alu593_cmd_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_wr_en(cmd_wr_en), .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
    .run(run), .cmd_count(cmd_count),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .busy(busy), .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [19:0] model_cmd [32];
  int exp_n = 0, issue_cnt = 0, cur_idx = 0, rises = 0, start_cycles = 0, done_pulses = 0, cyc = 0;
  logic prev_start = 1'b0, prev_busy = 1'b0;
  logic hang = 1'b0;
  logic [7:0] alu_cnt = 8'd0;

  // Behavioural ALU: done on the second cycle of start, result = A + B
  always @(negedge clk) begin
    if (!reset_n || !alu_start) begin
      alu_cnt  <= 8'd0;
      alu_done <= 1'b0;
    end else begin
      alu_cnt    <= alu_cnt + 8'd1;
      alu_done   <= !hang && (alu_cnt == 8'd1);
      alu_result <= {8'h00, alu_A} + {8'h00, alu_B};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the program model
  task automatic model_check();
    if (!reset_n) begin
      prev_start = 1'b0;
      prev_busy  = 1'b0;
      issue_cnt  = 0;
    end else begin
      if (alu_start && !prev_start) begin
        cur_idx = issue_cnt;
        issue_cnt++;
        rises++;
      end
      if (alu_start) begin
        start_cycles++;
        chk("issue_cmd", {12'd0, alu_op, alu_A, alu_B}, {12'd0, model_cmd[cur_idx % 32]});
        chk("start_implies_busy", busy, 1'b1);
      end
      if (seq_done) begin
        done_pulses++;
        chk("seq_issue_count", issue_cnt, exp_n);
        chk("done_err", err, 1'b0);
        chk("done_busy", busy, 1'b0);
      end
      if ((!busy && prev_busy) || seq_done) issue_cnt = 0;
      prev_start = alu_start;
      prev_busy  = busy;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_check();
  endtask

  task automatic wr(input int a, input logic [19:0] d);
    cmd_wr_en   = 1'b1;
    cmd_wr_addr = a[4:0];
    cmd_wr_data = d;
    model_cmd[a] = d;
    tick();
    cmd_wr_en = 1'b0;
  endtask

  task automatic rd(input int a, output logic [15:0] d);
    res_rd_addr = a[4:0];
    tick();
    d = res_rd_data;
  endtask

  task automatic start_run(input logic [5:0] c);
    run = 1'b1;
    cmd_count = c;
    cyc = 0;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    while (!seq_done && cyc < bound) tick();
    chk("seq_done_seen", seq_done, 1'b1);
  endtask

  initial begin
    logic [15:0] d;
    int s0, d0, r0;

    // Reset values
    tick(); tick();
    chk("rst_start", alu_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_seq_done", seq_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_data", res_rd_data, 16'd0);
    chk("rst_operands", {alu_op, alu_A, alu_B}, 20'd0);
    reset_n = 1'b1;
    tick();

    // Three ADD commands
    wr(0, {4'h1, 8'd5, 8'd3});
    wr(1, {4'h1, 8'd200, 8'd100});
    wr(2, {4'h1, 8'd255, 8'd255});
    exp_n = 3; d0 = done_pulses;
    start_run(6'd3);
    chk("busy_after_run", busy, 1'b1);
    wait_done(100);
    chk("seq3_latency", cyc, 13);
    tick(); tick(); tick();
    chk("seq3_done_once", done_pulses - d0, 1);
    chk("seq3_err", err, 1'b0);
    rd(0, d); chk("res0_add", d, 16'd8);
    rd(1, d); chk("res1_add", d, 16'd300);
    rd(2, d); chk("res2_add", d, 16'd510);

    // ALU never answers: timeout
    hang = 1'b1;
    wr(0, {4'h2, 8'd7, 8'd9});
    exp_n = 1; s0 = start_cycles; d0 = done_pulses;
    start_run(6'd1);
    while (busy && cyc < 200) tick();
    chk("to_busy", busy, 1'b0);
    chk("to_start_cycles", start_cycles - s0, 65);
    chk("to_err", err, 1'b1);
    chk("to_start_low", alu_start, 1'b0);
    chk("to_no_done", done_pulses - d0, 0);
    rd(0, d); chk("to_entry_kept", d, 16'd8);

    // No-op command
    hang = 1'b0;
    wr(0, {NOOP, 8'h12, 8'h34});
    exp_n = 1; s0 = start_cycles;
    start_run(6'd1);
    chk("err_cleared_by_run", err, 1'b0);
    wait_done(50);
    chk("noop_latency", cyc, 4);
    chk("noop_start_cycles", start_cycles - s0, 1);
    rd(0, d); chk("noop_result", d, 16'd0);

    // Reset in the middle of WAIT
    hang = 1'b1;
    wr(0, {4'h3, 8'd10, 8'd20});
    exp_n = 1;
    start_run(6'd1);
    tick(); tick(); tick();
    chk("pre_rst_start", alu_start, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_start", alu_start, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_op", alu_op, 4'h0);
    tick(); tick();
    reset_n = 1'b1;
    hang = 1'b0;
    tick();
    start_run(6'd1);
    wait_done(50);
    chk("post_rst_latency", cyc, 5);
    chk("post_rst_err", err, 1'b0);
    rd(0, d); chk("post_rst_result", d, 16'd30);
    rd(1, d); chk("retained_entry1", d, 16'd300);

    // Zero-length run
    exp_n = 0; r0 = rises;
    start_run(6'd0);
    chk("cnt0_done", seq_done, 1'b1);
    chk("cnt0_busy", busy, 1'b0);
    tick();
    chk("cnt0_pulse_width", seq_done, 1'b0);
    chk("cnt0_no_start", rises - r0, 0);

    // Count above DEPTH is clamped
    for (int i = 0; i < 32; i++) wr(i, {4'h1, 8'(i), 8'(2 * i)});
    exp_n = 32; r0 = rises;
    start_run(6'd40);
    wait_done(400);
    chk("clamp_latency", cyc, 129);
    chk("clamp_issues", rises - r0, 32);
    rd(31, d); chk("clamp_res31", d, 16'd93);
    rd(17, d); chk("clamp_res17", d, 16'd51);

    // Writes and run while busy are dropped
    wr(0, {4'h1, 8'd1, 8'd1});
    wr(1, {4'h1, 8'd2, 8'd2});
    exp_n = 2;
    start_run(6'd2);
    tick();
    cmd_wr_en = 1'b1; cmd_wr_addr = 5'd0; cmd_wr_data = {4'h5, 8'd99, 8'd99};
    run = 1'b1; cmd_count = 6'd1;
    tick();
    cmd_wr_en = 1'b0; run = 1'b0;
    wait_done(50);
    chk("busy_wr_latency", cyc, 9);
    rd(0, d); chk("busy_res0", d, 16'd2);
    rd(1, d); chk("busy_res1", d, 16'd4);
    exp_n = 1;
    start_run(6'd1);
    wait_done(50);
    rd(0, d); chk("cmd_mem_unchanged", d, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu593_cmd_sequencer.md
Name: alu593_cmd_sequencer

Overview:
Upstream command stage for the ALU593 datapath. A host loads a program of up to DEPTH ALU commands ({op, A, B}) into an internal command memory, then pulses run. The block issues each command to the ALU over the start/done handshake and writes each 16-bit ALU result into a result memory at the same index. The host reads results back through a registered read port.

Parameters:
DEPTH, 32, number of command/result entries; address width AW = 5 for the default.
NOOP_CODE, 4'h0, op encoding that produces no done from the ALU.
TIMEOUT, 64, maximum cycles to wait for alu_done before aborting.

Ports:
clk  input  1  single clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
cmd_wr_en  input  1  command memory write strobe.
cmd_wr_addr  input  AW  command memory write index.
cmd_wr_data  input  20  {op[19:16], A[15:8], B[7:0]}.
run  input  1  start-sequence pulse.
cmd_count  input  AW+1  number of commands to execute.
alu_A  output  8  operand A to ALU.
alu_B  output  8  operand B to ALU.
alu_op  output  4  op to ALU.
alu_start  output  1  ALU start.
alu_done  input  1  ALU completion.
alu_result  input  16  ALU result, valid while alu_done = 1.
res_rd_addr  input  AW  result read index.
res_rd_data  output  16  result read data, 1-cycle latency.
busy  output  1  sequence in progress.
seq_done  output  1  one-cycle pulse when a sequence completes normally.
err  output  1  sticky timeout flag.

Behaviour:
- Reset (async assert): alu_A/alu_B/alu_op = 0, alu_start = 0, busy = 0, seq_done = 0, err = 0, res_rd_data = 0, FSM = IDLE, ptr = 0. Memories are not reset and keep their contents.
- FSM states: IDLE, FETCH, ISSUE, WAIT, STORE, FINISH.
- IDLE:
  - run = 1 with cmd_count = 0: pulse seq_done next cycle; no issue.
  - run = 1 with cmd_count > 0: clamp cmd_count to DEPTH, latch it, clear err, ptr = 0, go to FETCH. busy = 1 from the next cycle until return to IDLE.
- FETCH (1 cycle): read cmd_mem[ptr] into the alu_op/alu_A/alu_B registers. Go to ISSUE.
- ISSUE (1 cycle): alu_start = 1.
  - If op == NOOP_CODE: next state STORE with result = 16'h0000. alu_start is high for exactly this one cycle.
  - Otherwise: go to WAIT with alu_start held high.
- WAIT:
  - alu_start stays 1. alu_A/alu_B/alu_op are stable throughout.
  - On a posedge with alu_done = 1: capture alu_result, deassert alu_start in the next cycle, go to STORE.
  - The wait counter increments each WAIT cycle. Reaching TIMEOUT: alu_start = 0, err = 1, go to IDLE with no seq_done; result entry not written.
- STORE (1 cycle): res_mem[ptr] = captured result.
  - If ptr == count-1: go to FINISH.
  - Otherwise: ptr++ and go to FETCH.
- FINISH: seq_done = 1 for one cycle, busy = 0, go to IDLE.
- Per-command latency: 3 + k cycles, where k = WAIT cycles up to and including alu_done. A no_op command takes 3 cycles.
- While busy: cmd_wr_en and run are ignored (writes dropped).
- Result read port: res_rd_data = res_mem[res_rd_addr] registered, 1-cycle latency, usable at any time. A read of the entry being written in the same cycle returns the old data.
- Reset mid-sequence: outputs go to reset values immediately. Results already stored are retained.
- Ops are passed through unmodified; the block does no arithmetic on A, B or result.

Test Plan:
- Load 3 commands (op 4'h1, A/B = 5/3, 200/100, 255/255); ALU model asserts done 2 cycles after start and returns A+B -> results 8, 300, 510 read back from entries 0..2; seq_done pulses once; err = 0.
- Single command with op = NOOP_CODE -> alu_start high exactly 1 cycle; entry 0 = 0; seq_done 3 cycles after FETCH.
- ALU model never asserts done -> alu_start drops after 64 WAIT cycles; err = 1; busy = 0; no seq_done; result entry unchanged.
- Assert reset_n = 0 during WAIT -> alu_start = 0 and busy = 0 asynchronously; after release a new run succeeds and clears err.
- run with cmd_count = 0 -> seq_done next cycle, no alu_start. run with cmd_count = 40 -> exactly 32 commands issued.
- cmd_wr_en and run asserted while busy -> command memory unchanged, sequence unaffected.
